// File: rtl/seq_state_detector.sv
// seq_state_detector: watches a W-bit symbol stream and pulses hit for each
// occurrence of a programmable pattern of up to DEPTH symbols. It supports
// overlapping and non-overlapping match modes, a saturating hit counter and
// a sticky illegal-command flag.
// Optional feature macro: SEQ_DET_MASK_EN adds pat_mask, a per-bit
// don't-care mask that is written alongside pat_data.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | not detecting; pattern memory is writable
// FILL  | armed; fewer than len symbols seen since arm or last non-overlap hit
// RUN   | armed; history holds len valid symbols, every symbol is a candidate
module seq_state_detector #(
  parameter int W     = 4,
  parameter int DEPTH = 8,
  parameter int CNT_W = 8,
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LEN_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             r,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  input  logic             pat_we,
  input  logic [IDX_W-1:0] pat_idx,
  input  logic [W-1:0]     pat_data,
`ifdef SEQ_DET_MASK_EN
  input  logic [W-1:0]     pat_mask,
`endif
  input  logic [LEN_W-1:0] pat_len,
  input  logic             overlap,
  input  logic             arm,
  input  logic             disarm,
  output logic             hit,
  output logic [CNT_W-1:0] hit_count,
  output logic [1:0]       state,
  output logic             err
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_RUN = 2'd2} state_t;

  state_t           r_state;
  logic [W-1:0]     r_pat  [DEPTH];
`ifdef SEQ_DET_MASK_EN
  logic [W-1:0]     r_mask [DEPTH];
`endif
  logic [W-1:0]     r_hist [DEPTH];
  logic [LEN_W-1:0] r_fill;
  logic [LEN_W-1:0] r_len;
  logic             r_ovl;
  logic             r_hit;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  logic [W-1:0]     w_hist_nxt [DEPTH];
  logic [LEN_W-1:0] w_fill_nxt;
  logic             w_match;
  logic             w_accept;
  logic             w_len_ok;
  logic             w_pat_wr;
  logic             w_pat_bad;
  logic             w_arm_bad;
  logic             w_hit;

  assign w_accept  = in_valid && (r_state != S_IDLE) && !arm && !disarm;
  assign w_len_ok  = (pat_len != '0) && (int'(pat_len) <= DEPTH);
  assign w_pat_wr  = pat_we && (r_state == S_IDLE) && !arm && (int'(pat_idx) < DEPTH);
  assign w_pat_bad = pat_we && !w_pat_wr;
  // disarm dominates arm, so a bad length alongside disarm is not an error
  assign w_arm_bad = arm && !disarm && !w_len_ok;
  assign w_fill_nxt = (r_fill >= r_len) ? r_len : r_fill + 1'b1;
  assign w_hit     = w_accept && w_match && (w_fill_nxt == r_len);

  // history as it will look after shifting in the current symbol (index 0 = newest)
  always_comb begin
    w_hist_nxt[0] = in_data;
    for (int i = 1; i < DEPTH; i++) w_hist_nxt[i] = r_hist[i-1];
  end

  // compare newest-i against pattern[len-1-i] for every i < len
  always_comb begin
    logic [W-1:0] care;
    w_match = 1'b1;
    care    = '1;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if ((i < int'(r_len)) && (j == int'(r_len) - 1 - i)) begin
`ifdef SEQ_DET_MASK_EN
          care = ~r_mask[j];
`else
          care = '1;
`endif
          if (((w_hist_nxt[i] ^ r_pat[j]) & care) != '0) w_match = 1'b0;
        end
      end
    end
  end

  // control FSM, pattern memory, history and registered outputs
  always_ff @(posedge clk) begin
    if (r) begin
      r_state <= S_IDLE;
      r_hit   <= 1'b0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_fill  <= '0;
      r_len   <= '0;
      r_ovl   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pat[i]  <= '0;
        r_hist[i] <= '0;
`ifdef SEQ_DET_MASK_EN
        r_mask[i] <= '0;
`endif
      end
    end else begin
      r_hit <= 1'b0;
      if (w_pat_bad || w_arm_bad) r_err <= 1'b1;
      if (w_pat_wr) begin
        r_pat[pat_idx] <= pat_data;
`ifdef SEQ_DET_MASK_EN
        r_mask[pat_idx] <= pat_mask;
`endif
      end
      if (disarm) begin
        r_state <= S_IDLE;
      end else if (arm) begin
        if (w_len_ok) begin
          r_len   <= pat_len;
          r_ovl   <= overlap;
          r_fill  <= '0;
          r_cnt   <= '0;
          r_state <= S_FILL;
          for (int i = 0; i < DEPTH; i++) r_hist[i] <= '0;
        end else begin
          r_state <= S_IDLE;
        end
      end else if (w_accept) begin
        for (int i = 0; i < DEPTH; i++) r_hist[i] <= w_hist_nxt[i];
        if (w_hit) begin
          r_hit <= 1'b1;
          if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
          if (!r_ovl) begin
            r_fill  <= '0;
            r_state <= S_FILL;
          end else begin
            r_fill  <= w_fill_nxt;
            r_state <= S_RUN;
          end
        end else begin
          r_fill  <= w_fill_nxt;
          r_state <= (w_fill_nxt == r_len) ? S_RUN : S_FILL;
        end
      end
    end
  end

  assign hit       = r_hit;
  assign hit_count = r_cnt;
  assign state     = r_state;
  assign err       = r_err;

endmodule

// File: tb/tb_seq_state_detector.sv
// Bench for seq_state_detector: directed vectors, a queue-based reference
// model checked every cycle, and literal expectations for the key scenarios.
module tb_seq_state_detector;
  localparam int W = 4, DEPTH = 8, CNT_W = 8;

  logic       clk = 1'b0;
  logic       r = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = '0;
  logic       pat_we = 1'b0;
  logic [2:0] pat_idx = '0;
  logic [3:0] pat_data = '0;
  logic [3:0] pat_mask = '0;
  logic [3:0] pat_len = '0;
  logic       overlap = 1'b0;
  logic       arm = 1'b0;
  logic       disarm = 1'b0;
  logic       hit;
  logic [7:0] hit_count;
  logic [1:0] state;
  logic       err;

  seq_state_detector #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .r(r), .in_valid(in_valid), .in_data(in_data),
    .pat_we(pat_we), .pat_idx(pat_idx), .pat_data(pat_data),
`ifdef SEQ_DET_MASK_EN
    .pat_mask(pat_mask),
`endif
    .pat_len(pat_len), .overlap(overlap), .arm(arm), .disarm(disarm),
    .hit(hit), .hit_count(hit_count), .state(state), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: the window holds symbols accepted since arm (or since the
  // last non-overlap hit), trimmed to len; a hit is a full window equal to the pattern
  logic [3:0] m_pat  [DEPTH];
  logic [3:0] m_mask [DEPTH];
  logic [3:0] m_win [$];
  int m_len = 0, m_state = 0, m_cnt = 0;
  bit m_ov = 0, m_hit = 0, m_err = 0;

  always @(posedge clk) begin
    bit eq;
    if (r) begin
      m_state = 0; m_hit = 0; m_cnt = 0; m_err = 0; m_len = 0; m_ov = 0;
      m_win.delete();
      for (int k = 0; k < DEPTH; k++) begin m_pat[k] = '0; m_mask[k] = '0; end
    end else begin
      m_hit = 0;
      if (pat_we) begin
        if (m_state == 0 && !arm && int'(pat_idx) < DEPTH) begin
          m_pat[pat_idx] = pat_data;
`ifdef SEQ_DET_MASK_EN
          m_mask[pat_idx] = pat_mask;
`endif
        end else m_err = 1;
      end
      if (disarm) m_state = 0;
      else if (arm) begin
        if (pat_len >= 1 && int'(pat_len) <= DEPTH) begin
          m_len = int'(pat_len); m_ov = overlap; m_cnt = 0; m_state = 1;
          m_win.delete();
        end else begin
          m_state = 0; m_err = 1;
        end
      end else if (in_valid && m_state != 0) begin
        m_win.push_back(in_data);
        if (m_win.size() > m_len) void'(m_win.pop_front());
        eq = (m_win.size() == m_len);
        for (int k = 0; k < m_win.size(); k++)
          if (((m_win[k] ^ m_pat[k]) & ~m_mask[k]) != 4'h0) eq = 0;
        if (eq) begin
          m_hit = 1;
          if (m_cnt < 255) m_cnt++;
          if (!m_ov) m_win.delete();
        end
        m_state = (m_win.size() == m_len) ? 2 : 1;
      end
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (started) begin
      chk("hit", int'(hit), int'(m_hit));
      chk("hit_count", int'(hit_count), m_cnt);
      chk("state", int'(state), m_state);
      chk("err", int'(err), int'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    r = 1'b1; tick(); r = 1'b0;
  endtask

  task automatic wr(input logic [2:0] idx, input logic [3:0] d, input logic [3:0] m);
    pat_we = 1'b1; pat_idx = idx; pat_data = d; pat_mask = m;
    tick();
    pat_we = 1'b0; pat_mask = '0;
  endtask

  task automatic do_arm(input logic [3:0] len, input logic ov, input logic iv);
    arm = 1'b1; pat_len = len; overlap = ov; in_valid = iv; in_data = 4'hA;
    tick();
    arm = 1'b0; in_valid = 1'b0;
  endtask

  task automatic feed(input logic [3:0] s, output logic h);
    in_valid = 1'b1; in_data = s;
    tick();
    in_valid = 1'b0;
    h = hit;
  endtask

  task automatic stream_abab(output logic [6:0] hits);
    logic [3:0] seq [7];
    logic h;
    seq = '{4'hA, 4'hB, 4'hA, 4'hB, 4'hA, 4'hB, 4'hA};
    hits = '0;
    for (int k = 0; k < 7; k++) begin
      feed(seq[k], h);
      hits[k] = h;
    end
  endtask

  task automatic load_aba();
    wr(3'd0, 4'hA, 4'h0); wr(3'd1, 4'hB, 4'h0); wr(3'd2, 4'hA, 4'h0);
  endtask

  initial begin
    logic [6:0] hits;
    logic h;
    tick();
    started = 1'b1;
    do_reset();
    chk("rst_state", int'(state), 0);
    chk("rst_hit", int'(hit), 0);
    chk("rst_count", int'(hit_count), 0);
    chk("rst_err", int'(err), 0);

    // overlapping mode
    load_aba();
    do_arm(4'd3, 1'b1, 1'b0);
    chk("ovl_armed_state", int'(state), 1);
    stream_abab(hits);
    chk("ovl_hits", int'(hits), 7'b1010100);
    chk("ovl_count", int'(hit_count), 3);
    chk("ovl_state", int'(state), 2);

    // non-overlapping mode; the symbol in the arm cycle must be dropped
    do_arm(4'd3, 1'b0, 1'b1);
    stream_abab(hits);
    chk("novl_hits", int'(hits), 7'b1000100);
    chk("novl_count", int'(hit_count), 2);
    chk("novl_state", int'(state), 1);
    chk("novl_err", int'(err), 0);

    // disarm dominates arm
    arm = 1'b1; disarm = 1'b1; pat_len = 4'd3; tick(); arm = 1'b0; disarm = 1'b0;
    chk("disarm_dom", int'(state), 0);

    // illegal lengths
    do_arm(4'd0, 1'b1, 1'b0);
    chk("len0_err", int'(err), 1);
    chk("len0_state", int'(state), 0);
    do_reset();
    do_arm(4'd9, 1'b1, 1'b0);
    chk("len9_err", int'(err), 1);
    chk("len9_state", int'(state), 0);

    // pattern write while RUN is rejected
    do_reset();
    load_aba();
    do_arm(4'd3, 1'b1, 1'b0);
    feed(4'hA, h); feed(4'hB, h); feed(4'hA, h);
    chk("run_state", int'(state), 2);
    wr(3'd1, 4'hC, 4'h0);
    chk("we_run_err", int'(err), 1);
    do_arm(4'd3, 1'b1, 1'b0);
    stream_abab(hits);
    chk("we_run_hits", int'(hits), 7'b1010100);

    // saturation and disarm
    do_reset();
    wr(3'd0, 4'h5, 4'h0);
    do_arm(4'd1, 1'b0, 1'b0);
    for (int k = 0; k < 300; k++) feed(4'h5, h);
    chk("sat_count", int'(hit_count), 255);
    disarm = 1'b1; tick(); disarm = 1'b0;
    chk("disarm_state", int'(state), 0);
    chk("disarm_held", int'(hit_count), 255);
    do_arm(4'd1, 1'b0, 1'b0);
    chk("rearm_count", int'(hit_count), 0);
    chk("rearm_state", int'(state), 1);

    // mid-operation reset clears the pattern memory
    do_reset();
    load_aba();
    do_arm(4'd3, 1'b1, 1'b0);
    feed(4'hA, h); feed(4'hB, h);
    do_reset();
    chk("midrst_state", int'(state), 0);
    do_arm(4'd3, 1'b1, 1'b0);
    feed(4'hA, h);
    chk("midrst_nohit", int'(h), 0);
    feed(4'h0, h); feed(4'h0, h);
    chk("midrst_zero_pre", int'(h), 0);
    feed(4'h0, h);
    chk("midrst_zero_hit", int'(h), 1);

`ifdef SEQ_DET_MASK_EN
    do_reset();
    wr(3'd0, 4'h0, 4'hF);
    do_arm(4'd1, 1'b0, 1'b0);
    feed(4'h7, h);
    chk("mask_hit", int'(h), 1);
`endif

    tick();
    started = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
